// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding select codes, register constants and multiply latency
// shared by the hazard controller and the Execute-stage operand mux.
package hazard_pkg;
    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [3:0] REG_PC      = 4'd15;
    localparam int         MUL_LAT_DEF = 3;

    // Memory stage wins over Writeback because it holds the younger result; R15 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       rw_m,
        input logic [3:0] wa_m,
        input logic       rw_w,
        input logic [3:0] wa_w,
        input logic [3:0] ra
    );
        return (ra == REG_PC)           ? FWD_RF :
               (rw_m && (wa_m == ra))   ? FWD_M  :
               (rw_w && (wa_w == ra))   ? FWD_W  : FWD_RF;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding selects, load-use / multiply stalls, branch flushes
// and saturating stall/flush event counters for the 5-stage core.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic             MulE,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             BubbleM,
    output logic             MulBusy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    logic [3:0] r_mul_cnt;
    logic [3:0] w_mul_cnt_nxt;
    logic       w_ldr_stall;
    logic       w_mul_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_mul_cnt <= '0;
        else
            r_mul_cnt <= w_mul_cnt_nxt;
    end

    // Every output is gated by reset so the pipeline sees a clean idle controller while it is held.
    always_comb begin
        w_ldr_stall   = MemtoRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
        w_mul_stall   = MulE && (r_mul_cnt < MUL_LAST);
        w_mul_cnt_nxt = w_mul_stall ? r_mul_cnt + 4'd1 : 4'd0;
        ForwardA      = reset ? FWD_RF : fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
        ForwardB      = reset ? FWD_RF : fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);
        StallF        = !reset && (w_ldr_stall || w_mul_stall);
        StallD        = !reset && (w_ldr_stall || w_mul_stall) && !BranchTakenE;
        StallE        = !reset && w_mul_stall;
        FlushD        = !reset && BranchTakenE;
        FlushE        = !reset && (w_ldr_stall || BranchTakenE) && !w_mul_stall;
        BubbleM       = !reset && w_mul_stall;
        MulBusy       = !reset && (r_mul_cnt != 4'd0);
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushE),
        .count (FlushCount)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stalls, flushes, multiply
// sequencing, asynchronous reset and counter saturation.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulE;
    logic [1:0]  ForwardA, ForwardB;
    logic        StallF, StallD, StallE, FlushD, FlushE, BubbleM, MulBusy;
    logic [15:0] StallCount, FlushCount;
    int          ntot = 0;
    int          npass = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MulE(MulE),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM), .MulBusy(MulBusy),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulE} = '0;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
        #12;
        chk("rst_fwdA", ForwardA, 2'b00);
        chk("rst_stallF", StallF, 1'b0);
        chk("rst_cnts", {StallCount, FlushCount}, 32'h0);

        @(negedge clk) reset = 1'b0;
        #1 chk("fwdA_M", ForwardA, 2'b10);
        WA3W = 4'd3; RegWriteW = 1'b1;
        #1 chk("fwdA_M_over_W", ForwardA, 2'b10);
        RegWriteM = 1'b0;
        #1 chk("fwdA_W", ForwardA, 2'b01);
        RA2E = 4'd15; WA3M = 4'd15; WA3W = 4'd15; RegWriteM = 1'b1;
        #1 chk("fwdB_pc", ForwardB, 2'b00);
        RA2E = 4'd7; WA3W = 4'd7;
        #1 chk("fwdB_W", ForwardB, 2'b01);
        chk("fwd_no_stall", {StallF, StallD, StallE, FlushD, FlushE, BubbleM}, 6'b0);

        @(negedge clk) clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 5'd5;
        #1 chk("ldr_ctl", {StallF, StallD, FlushE, StallE, FlushD}, 5'b11100);
        edge_sample();
        chk("ldr_cnts", {StallCount, FlushCount}, {16'd1, 16'd1});

        @(negedge clk) BranchTakenE = 1'b1;
        #1 chk("br_ldr_ctl", {FlushD, FlushE, StallD, StallF}, 4'b1101);
        edge_sample();
        chk("br_ldr_cnts", {StallCount, FlushCount}, {16'd2, 16'd2});

        @(negedge clk) clear_inputs();
        MulE = 1'b1;
        #1 chk("mul_c0", {StallE, BubbleM, MulBusy, FlushE}, 4'b1100);
        edge_sample();
        chk("mul_c1", {StallE, BubbleM, MulBusy}, 3'b111);
        edge_sample();
        chk("mul_c2", {StallE, BubbleM, MulBusy, StallF}, 4'b0010);
        edge_sample();
        chk("mul_b2b", {StallE, MulBusy}, 2'b10);
        @(negedge clk) MulE = 1'b0;
        #1 chk("mul_drop", {StallE, MulBusy}, 2'b00);
        edge_sample();
        chk("mul_cnts", {StallCount, FlushCount}, {16'd4, 16'd2});

        @(negedge clk) MulE = 1'b1;
        edge_sample();
        chk("rmul_busy", MulBusy, 1'b1);
        #2 reset = 1'b1;
        #1 chk("rmul_outs", {StallF, StallD, StallE, FlushD, FlushE, BubbleM, MulBusy}, 7'b0);
        chk("rmul_cnts", {StallCount, FlushCount}, 32'h0);
        @(negedge clk) reset = 1'b0;
        #1 chk("rmul_s0", {StallE, MulBusy}, 2'b10);
        edge_sample();
        chk("rmul_s1", {StallE, MulBusy}, 2'b11);
        edge_sample();
        chk("rmul_s2", StallE, 1'b0);
        @(negedge clk) MulE = 1'b0;
        #1 chk("rmul_cnt", StallCount, 16'd2);

        @(negedge clk) clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd9; RA1D = 4'd9;
        repeat (70000) @(posedge clk);
        #1 chk("sat_stall", StallCount, 16'hFFFF);
        chk("sat_flush", FlushCount, 16'hFFFF);
        repeat (3) edge_sample();
        chk("sat_hold", {StallCount, FlushCount}, 32'hFFFF_FFFF);
        @(negedge clk) clear_inputs();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
